// File: rtl/mem_initiator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_initiator_if: command/response channels plus native memory bus   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_instr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem__mem_valid;
  logic        mem__mem_instr;
  logic [31:0] mem__mem_addr;
  logic [31:0] mem__mem_wdata;
  logic [3:0]  mem__mem_wstrb;
  logic        mem__mem_ready;
  logic [31:0] mem__mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_instr, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output mem__mem_valid, mem__mem_instr, mem__mem_addr, mem__mem_wdata, mem__mem_wstrb,
    input  mem__mem_ready, mem__mem_rdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_instr, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  mem__mem_valid, mem__mem_instr, mem__mem_addr, mem__mem_wdata, mem__mem_wstrb,
    output mem__mem_ready, mem__mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_initiator: single-outstanding bus initiator with request timeout |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clock,
  input  logic            reset,
  mem_initiator_if.master bus,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state;
  logic [31:0]      r_addr, w_addr;
  logic [31:0]      r_wdata, w_wdata;
  logic [3:0]       r_wstrb, w_wstrb;
  logic             r_instr, w_instr;
  logic             r_write, w_write;
  logic [31:0]      r_rdata, w_rdata;
  logic             r_error, w_error;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_instr <= 1'b0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_wstrb <= w_wstrb;
      r_instr <= w_instr;
      r_write <= w_write;
      r_rdata <= w_rdata;
      r_error <= w_error;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_wstrb = r_wstrb;
    w_instr = r_instr;
    w_write = r_write;
    w_rdata = r_rdata;
    w_error = r_error;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_addr  = bus.cmd_addr & 32'hFFFF_FFFC;
          w_wdata = bus.cmd_wdata;
          w_instr = bus.cmd_instr;
          w_write = bus.cmd_write;
          w_wstrb = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
          w_rdata = '0;
          w_error = 1'b0;
          w_cnt   = '0;
          // A write that enables no bytes has nothing to do on the bus.
          if (bus.cmd_write && (bus.cmd_wstrb == 4'b0000)) begin
            w_state = S_RSP;
          end else begin
            w_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem__mem_ready) begin
          w_rdata = r_write ? 32'h0 : bus.mem__mem_rdata;
          w_error = 1'b0;
          w_state = S_RSP;
        end else if (r_cnt == c_cnt_last) begin
          w_rdata = '0;
          w_error = 1'b1;
          w_state = S_RSP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Valid is decoded from state so an asynchronous reset drops it at once.
  assign bus.cmd_ready      = (r_state == S_IDLE);
  assign bus.mem__mem_valid = (r_state == S_REQ);
  assign bus.mem__mem_instr = r_instr;
  assign bus.mem__mem_addr  = r_addr;
  assign bus.mem__mem_wdata = r_wdata;
  assign bus.mem__mem_wstrb = r_wstrb;
  assign bus.rsp_valid      = (r_state == S_RSP);
  assign bus.rsp_rdata      = r_rdata;
  assign bus.rsp_error      = r_error;
  assign busy               = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// Testbench for mem_initiator: table vectors, random transactions against a
// transaction-level model, and asynchronous reset mid-request.
module tb_mem_initiator;
  localparam int TO = 8;

  logic clock;
  logic reset;
  logic busy;
  int   n_checks;
  int   n_errors;

  mem_initiator_if u_if ();

  mem_initiator #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if),
    .busy  (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic        write;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;     // REQ cycles without ready before the target answers
    int          hold;       // cycles rsp_ready is withheld
    logic [31:0] tgt_rdata;
    int          exp_vcyc;
    logic        exp_error;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation derived from the command and target behaviour.
  function automatic txn_t model(input txn_t t);
    txn_t r;
    r = t;
    r.exp_addr  = t.addr & 32'hFFFF_FFFC;
    r.exp_wstrb = t.write ? t.wstrb : 4'b0000;
    if (t.write && t.wstrb == 4'b0000) begin
      r.exp_vcyc  = 0;
      r.exp_error = 1'b0;
      r.exp_rdata = 32'h0;
    end else if (t.wait_n + 1 <= TO) begin
      r.exp_vcyc  = t.wait_n + 1;
      r.exp_error = 1'b0;
      r.exp_rdata = t.write ? 32'h0 : t.tgt_rdata;
    end else begin
      r.exp_vcyc  = TO;
      r.exp_error = 1'b1;
      r.exp_rdata = 32'h0;
    end
    return r;
  endfunction

  task automatic junk_cmd();
    u_if.cmd_write = 1'($urandom_range(0, 1));
    u_if.cmd_instr = 1'($urandom_range(0, 1));
    u_if.cmd_addr  = $urandom;
    u_if.cmd_wdata = $urandom;
    u_if.cmd_wstrb = 4'($urandom_range(0, 15));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_txn(input txn_t t);
    int          n_v;
    logic        done;
    logic [31:0] held_rdata;
    logic        held_error;
    chk("idle_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    u_if.cmd_valid      = 1'b1;
    u_if.cmd_write      = t.write;
    u_if.cmd_instr      = t.instr;
    u_if.cmd_addr       = t.addr;
    u_if.cmd_wdata      = t.wdata;
    u_if.cmd_wstrb      = t.wstrb;
    u_if.rsp_ready      = 1'b0;
    u_if.mem__mem_ready = 1'b0;
    @(negedge clock);
    u_if.cmd_valid = 1'b0;
    junk_cmd();
    n_v  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < TO + 20 && !done; cyc++) begin
      if (u_if.rsp_valid) begin
        done = 1'b1;
      end else begin
        if (u_if.mem__mem_valid) begin
          n_v++;
          chk("bus_addr", u_if.mem__mem_addr, t.exp_addr);
          chk("bus_wstrb", 32'(u_if.mem__mem_wstrb), 32'(t.exp_wstrb));
          chk("bus_wdata", u_if.mem__mem_wdata, t.wdata);
          chk("bus_instr", 32'(u_if.mem__mem_instr), 32'(t.instr));
          u_if.mem__mem_ready = (n_v == t.wait_n + 1);
          u_if.mem__mem_rdata = u_if.mem__mem_ready ? t.tgt_rdata : $urandom;
        end else begin
          u_if.mem__mem_ready = 1'b0;
        end
        @(negedge clock);
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_wait: got no rsp_valid expected rsp_valid within %0d cycles", TO + 20);
    end
    chk("valid_cycles", 32'(n_v), 32'(t.exp_vcyc));
    chk("valid_low_in_rsp", 32'(u_if.mem__mem_valid), 32'd0);
    chk("rsp_error", 32'(u_if.rsp_error), 32'(t.exp_error));
    chk("rsp_rdata", u_if.rsp_rdata, t.exp_rdata);
    held_rdata = u_if.rsp_rdata;
    held_error = u_if.rsp_error;
    for (int h = 0; h < t.hold; h++) begin
      u_if.cmd_valid      = 1'b1;
      junk_cmd();
      u_if.mem__mem_ready = 1'($urandom_range(0, 1));
      u_if.mem__mem_rdata = $urandom;
      @(negedge clock);
      chk("hold_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", u_if.rsp_rdata, held_rdata);
      chk("hold_rsp_error", 32'(u_if.rsp_error), 32'(held_error));
      chk("hold_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
    end
    u_if.cmd_valid      = 1'b1;
    junk_cmd();
    u_if.rsp_ready      = 1'b1;
    u_if.mem__mem_ready = 1'b0;
    @(negedge clock);
    u_if.cmd_valid = 1'b0;
    u_if.rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_mem_valid", 32'(u_if.mem__mem_valid), 32'd0);
  endtask

  txn_t vec [8];
  txn_t t;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    u_if.cmd_valid      = 1'b0;
    u_if.cmd_write      = 1'b0;
    u_if.cmd_instr      = 1'b0;
    u_if.cmd_addr       = 32'h0;
    u_if.cmd_wdata      = 32'h0;
    u_if.cmd_wstrb      = 4'h0;
    u_if.rsp_ready      = 1'b0;
    u_if.mem__mem_ready = 1'b0;
    u_if.mem__mem_rdata = 32'h0;

    //          wr    in    addr          wdata         wstrb wait hold tgt_rdata     vcyc err   rdata         addr          wstrb
    vec[0] = '{1'b1, 1'b0, 32'h2000_0000, 32'h1234_abcd, 4'hF, 0,   0,  32'h0000_0000, 1,   1'b0, 32'h0000_0000, 32'h2000_0000, 4'hF};
    vec[1] = '{1'b0, 1'b0, 32'h2000_0002, 32'h0000_0000, 4'h0, 3,   0,  32'hcafe_f00d, 4,   1'b0, 32'hcafe_f00d, 32'h2000_0000, 4'h0};
    vec[2] = '{1'b0, 1'b0, 32'h0000_0010, 32'h1111_2222, 4'h0, 100, 0,  32'hdead_beef, 8,   1'b1, 32'h0000_0000, 32'h0000_0010, 4'h0};
    vec[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 4'h0, 7,   0,  32'h55aa_55aa, 8,   1'b0, 32'h55aa_55aa, 32'h0000_0014, 4'h0};
    vec[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h8765_4321, 4'h3, 1,   5,  32'hffff_ffff, 2,   1'b0, 32'h0000_0000, 32'h0000_0040, 4'h3};
    vec[5] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0bad_0bad, 4'h0, 0,   1,  32'hffff_ffff, 0,   1'b0, 32'h0000_0000, 32'h0000_0080, 4'h0};
    vec[6] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 4'h0, 2,   2,  32'h0bad_f00d, 3,   1'b0, 32'h0bad_f00d, 32'h0000_0000, 4'h0};
    vec[7] = '{1'b1, 1'b0, 32'hffff_fffe, 32'ha5a5_a5a5, 4'h8, 50,  0,  32'h1234_5678, 8,   1'b1, 32'h0000_0000, 32'hffff_fffc, 4'h8};

    #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_mem_valid", 32'(u_if.mem__mem_valid), 32'd0);
    chk("rst_mem_addr", u_if.mem__mem_addr, 32'h0);
    chk("rst_mem_wdata", u_if.mem__mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(u_if.mem__mem_wstrb), 32'd0);
    chk("rst_mem_instr", 32'(u_if.mem__mem_instr), 32'd0);
    chk("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", u_if.rsp_rdata, 32'h0);
    chk("rst_rsp_error", 32'(u_if.rsp_error), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_cmd_ready", 32'(u_if.cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vec[i]);
    end

    // Asynchronous reset during the second wait cycle of a read.
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = 1'b0;
    u_if.cmd_instr = 1'b0;
    u_if.cmd_addr  = 32'h3000_0008;
    u_if.cmd_wstrb = 4'h0;
    @(negedge clock);
    u_if.cmd_valid = 1'b0;
    chk("mid_valid_c1", 32'(u_if.mem__mem_valid), 32'd1);
    @(negedge clock);
    chk("mid_valid_c2", 32'(u_if.mem__mem_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid_drop", 32'(u_if.mem__mem_valid), 32'd0);
    chk("async_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("after_rst_no_rsp", 32'(u_if.rsp_valid), 32'd0);
    end
    chk("after_rst_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    t = '{1'b0, 1'b0, 32'h3000_0008, 32'h0, 4'h0, 1, 0, 32'h7777_8888, 0, 1'b0, 32'h0, 32'h0, 4'h0};
    run_txn(model(t));

    for (int i = 0; i < 40; i++) begin
      t.write     = 1'($urandom_range(0, 1));
      t.instr     = 1'($urandom_range(0, 1));
      t.addr      = $urandom;
      t.wdata     = $urandom;
      t.wstrb     = 4'($urandom_range(0, 15));
      t.wait_n    = $urandom_range(0, 10);
      t.hold      = $urandom_range(0, 3);
      t.tgt_rdata = $urandom;
      run_txn(model(t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
